// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared constants and types for the coprocessor-0 exception sequencer
//
// Purpose: cause codes, sequencer state encoding and c0 register selects.
// Ports:   none (package).

package exc_pkg;

  // CAUSE.code values
  localparam logic [2:0] CAUSE_OVF  = 3'b001;
  localparam logic [2:0] CAUSE_PRIV = 3'b010;
  localparam logic [2:0] CAUSE_ILL  = 3'b011;
  localparam logic [2:0] CAUSE_IRQ  = 3'b100;
  localparam logic [2:0] CAUSE_DBL  = 3'b111;

  typedef enum logic [1:0] {
    USER   = 2'd0,
    KERNEL = 2'd1,
    HALT   = 2'd2
  } state_t;

  // c0_sel encodings; select 3 reads 0 and ignores writes
  localparam logic [1:0] C0_STATUS = 2'd0;
  localparam logic [1:0] C0_CAUSE  = 2'd1;
  localparam logic [1:0] C0_EPC    = 2'd2;

endpackage

// File: rtl/exc_sequencer.sv
// rtl/exc_sequencer.sv - coprocessor-0 exception sequencer (STATUS/CAUSE/EPC, user/kernel FSM)
//
// Purpose: owns STATUS, CAUSE and EPC, samples external interrupts, and
//          decides when fetch must redirect to an exception vector.
// Ports:
//   clk, reset                 core clock, synchronous active-high reset
//   int_cause, cause_write     synchronous exception report from the decoder
//   exit_kernel, write_c0      kernel-return and c0-write indications
//   c0_sel, c0_wdata, c0_rdata c0 register access (read is combinational)
//   pc                         PC of the instruction in execute
//   irq                        level-sensitive external interrupt lines
//   kernel_mode, halted        registered mode outputs
//   exc_take, exc_vector       combinational fetch redirect / squash
//   epc                        return target for exit_kernel

module exc_sequencer
  import exc_pkg::*;
#(
  parameter int          N_IRQ      = 4,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter logic [31:0] IRQ_VECTOR = 32'h0000_00A0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        int_cause,
  input  logic              cause_write,
  input  logic              exit_kernel,
  input  logic              write_c0,
  input  logic [1:0]        c0_sel,
  input  logic [31:0]       c0_wdata,
  output logic [31:0]       c0_rdata,
  input  logic [31:0]       pc,
  input  logic [N_IRQ-1:0]  irq,
  output logic              kernel_mode,
  output logic              exc_take,
  output logic [31:0]       exc_vector,
  output logic [31:0]       epc,
  output logic              halted
);

  state_t             r_state;
  logic               r_ie;
  logic [N_IRQ-1:0]   r_mask;
  logic [2:0]         r_code;
  logic [N_IRQ-1:0]   r_cause_irq;
  logic [31:0]        r_epc;
  logic [N_IRQ-1:0]   r_irq_q;
  logic               r_kernel_mode;
  logic               r_halted;

  logic               w_pending;
  logic [31:0]        w_status;
  logic [31:0]        w_cause;

  // Interrupts are judged on the registered copy only, so a line raised
  // before edge n can first redirect fetch in the cycle after edge n.
  assign w_pending = (|(r_irq_q & r_mask)) & r_ie;

  assign w_status = 32'({r_mask, r_ie});
  assign w_cause  = 32'({r_cause_irq, r_code});

  assign kernel_mode = r_kernel_mode;
  assign halted      = r_halted;
  assign epc         = r_epc;

  always_comb begin
    c0_rdata = 32'd0;
    case (c0_sel)
      C0_STATUS: c0_rdata = w_status;
      C0_CAUSE:  c0_rdata = w_cause;
      C0_EPC:    c0_rdata = r_epc;
      default:   c0_rdata = 32'd0;
    endcase
  end

  // Synchronous exceptions beat interrupts; in KERNEL only a double fault
  // redirects, and HALT never does.
  always_comb begin
    exc_take   = 1'b0;
    exc_vector = EXC_VECTOR;
    if (!reset) begin
      case (r_state)
        USER: begin
          if (cause_write) begin
            exc_take   = 1'b1;
            exc_vector = EXC_VECTOR;
          end else if (w_pending) begin
            exc_take   = 1'b1;
            exc_vector = IRQ_VECTOR;
          end
        end
        KERNEL: begin
          if (cause_write) begin
            exc_take   = 1'b1;
            exc_vector = EXC_VECTOR;
          end
        end
        default: begin
          exc_take   = 1'b0;
          exc_vector = EXC_VECTOR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= USER;
      r_ie          <= 1'b0;
      r_mask        <= '0;
      r_code        <= 3'd0;
      r_cause_irq   <= '0;
      r_epc         <= 32'd0;
      r_irq_q       <= '0;
      r_kernel_mode <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_irq_q <= irq;
      case (r_state)
        USER: begin
          if (cause_write) begin
            r_code        <= int_cause;
            r_cause_irq   <= r_irq_q;
            r_epc         <= pc;
            r_state       <= KERNEL;
            r_kernel_mode <= 1'b1;
          end else if (w_pending) begin
            // The interrupted instruction is squashed and re-runs on return.
            r_code        <= CAUSE_IRQ;
            r_cause_irq   <= r_irq_q;
            r_epc         <= pc;
            r_state       <= KERNEL;
            r_kernel_mode <= 1'b1;
          end
        end
        KERNEL: begin
          if (cause_write) begin
            // Double fault: EPC keeps the original return point.
            r_code   <= CAUSE_DBL;
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else if (exit_kernel) begin
            r_state       <= USER;
            r_kernel_mode <= 1'b0;
          end else if (write_c0) begin
            case (c0_sel)
              C0_STATUS: begin
                r_ie   <= c0_wdata[0];
                r_mask <= c0_wdata[N_IRQ:1];
              end
              C0_CAUSE: begin
                r_code      <= c0_wdata[2:0];
                r_cause_irq <= c0_wdata[N_IRQ+2:3];
              end
              C0_EPC: begin
                r_epc <= c0_wdata;
              end
              default: begin
              end
            endcase
          end
        end
        HALT: begin
        end
        default: begin
          r_state       <= USER;
          r_kernel_mode <= 1'b0;
          r_halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule
